scpu_loader: RTL and testbench
==============================

# scpu_loader

Instruction-memory boot controller for the SCPU core. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them to consecutive SCPU instruction-memory entries through the core's `ins_index`/`ins_we`/`instructs` write port. It then fills the unused tail with NOPs and releases the core with `cpu_run`. It sits between the host/test loader and SCPU and is the only writer of SCPU instruction memory.

## Interface
Parameters:
- `ADDR_W`, 8: width of `ins_index`.
- `INS_W`, 16: instruction word width.
- `DEPTH`, 128: number of instruction-memory entries. Must be ≤ 2^ADDR_W.
- `NOP`, 16'h0000: fill word written to unused entries.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load when IDLE.
- `stop`  in  1  single-cycle pulse; ends RUN, returns to IDLE.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  controller can accept a word.
- `s_data`  in  INS_W  instruction word.
- `s_last`  in  1  marks the final word of the program.
- `ins_index`  out  ADDR_W  SCPU instruction-memory write address.
- `ins_we`  out  1  SCPU instruction-memory write enable.
- `instructs`  out  INS_W  SCPU instruction-memory write data.
- `cpu_run`  out  1  SCPU released to execute.
- `busy`  out  1  high in LOAD or FILL.
- `count`  out  ADDR_W+1  number of program words accepted in the last or current load.
- `err_overflow`  out  1  sticky; program exceeded DEPTH words.

## Operation
- FSM states: IDLE, LOAD, FILL, RUN.
- **IDLE**
  - `start` → LOAD. Clears the write pointer, `count` and `err_overflow`.
  - `stop` is ignored.
- **LOAD**
  - `s_ready` = 1.
  - Each beat (`s_valid && s_ready`) writes `s_data` at `ptr`, then increments `ptr` and `count`.
  - A beat with `s_last`, or the beat that makes `ptr` reach DEPTH, leaves LOAD.
  - If `ptr` < DEPTH after that beat → FILL. Otherwise → RUN.
- **Overflow**
  - If the DEPTH-th word arrives without `s_last`, that word is still written.
  - `err_overflow` sets, the FSM goes to IDLE without running, and `s_ready` drops.
  - No wrap-around: entry 0 is never overwritten within one load.
- **FILL**
  - `s_ready` = 0.
  - Writes `NOP` to one entry per cycle, from `ptr` up to DEPTH-1, then → RUN.
- **RUN**
  - `cpu_run` = 1; write port idle.
  - `stop` → IDLE and `cpu_run` drops.
  - `start` is ignored.
- `start` outside IDLE is ignored. `start` and `stop` asserted together in IDLE: `start` wins.
- Zero-length program: not possible, since the first beat is always a word.
- `count` holds its value after the load until the next `start`.

## Timing
- All outputs are registered.
- Reset values: `s_ready`=0, `ins_index`=0, `ins_we`=0, `instructs`=0, `cpu_run`=0, `busy`=0, `count`=0, `err_overflow`=0. FSM state is IDLE.
- `start` at edge N → LOAD at N+1; `s_ready` and `busy` are high from cycle N+1.
- A beat accepted at edge K appears on `ins_we`/`ins_index`/`instructs` during cycle K+1 (one-cycle latency). The write port carries at most one write per cycle.
- `s_ready` is a function of state only. Back-to-back beats are sustained at one per cycle.
- FILL takes exactly (DEPTH − words) cycles. Its first NOP write directly follows the last program write, with no gap.
- `cpu_run` rises the cycle after the last write (program or NOP) is presented. `busy` falls the same cycle.
- Reset mid-LOAD or mid-FILL: outputs return to reset values immediately. Memory contents are partial and undefined, `cpu_run` stays 0, and the next load is required.

## Structure
- Shared package `scpu_pkg` holds:
  - FSM state enum.
  - `INS_W`, `ADDR_W`, `DEPTH` defaults.
  - `NOP` encoding.
  - Instruction-word typedef.
- No sub-module. Optional `scpu_loader_wport` register slice may own the output register stage. Default: single module.

## Test plan
- Full-length load: 128 beats 16'h0001..16'h0080, `s_last` on the 128th → addresses 0..127 written with those values, no FILL, `cpu_run` high 1 cycle after write 127, `count`=128.
- Short program: 3 beats (16'hA001, 16'hA002, 16'hA003 with `s_last`) → writes at 0..2, NOP writes 3..127 on 125 consecutive cycles, then `cpu_run`=1, `count`=3.
- Handshake gaps: `s_valid` toggled 1/0 every cycle over 10 words → only accepted beats are written, indices contiguous 0..9, no duplicates.
- Overflow: 129 beats without `s_last` → 128 writes (0..127), `err_overflow`=1, `s_ready`=0, `cpu_run` never rises, FSM in IDLE.
- Reset mid-load: `rst` asserted after 5 beats → all outputs 0 within the reset; a new `start` then loads from index 0 with `count` restarting at 0.
- Control corner cases: `start` during RUN ignored; `stop` in RUN → `cpu_run` falls next cycle; `start`+`stop` together in IDLE → LOAD.

Source files
------------

// File: rtl/scpu_pkg.sv
// scpu_pkg
//   Shared definitions for the SCPU boot path: default instruction-memory
//   geometry, the NOP fill encoding, the instruction word type and the
//   loader FSM state encoding.
package scpu_pkg;

  localparam int INS_W_DEF  = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 128;

  typedef logic [INS_W_DEF-1:0] ins_word_t;

  localparam ins_word_t NOP_INS = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_RUN  = 2'd3
  } load_state_t;

endpackage

// File: rtl/scpu_loader.sv
// scpu_loader
//   Instruction-memory boot controller for the SCPU core. Accepts program
//   words over a valid/ready stream, writes them to consecutive memory
//   entries, pads the remaining entries with NOP and then releases the core.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, stop         one-cycle control pulses (load request / halt core)
//   s_valid, s_ready    input stream handshake
//   s_data, s_last      program word and end-of-program marker
//   ins_index, ins_we,
//   instructs           SCPU instruction-memory write port
//   cpu_run             core released to execute
//   busy                load or NOP fill in progress
//   count               program words accepted by the last/current load
//   err_overflow        sticky: program longer than DEPTH words
module scpu_loader
  import scpu_pkg::*;
#(
  parameter int               ADDR_W = ADDR_W_DEF,
  parameter int               INS_W  = INS_W_DEF,
  parameter int               DEPTH  = DEPTH_DEF,
  parameter logic [INS_W-1:0] NOP    = INS_W'(NOP_INS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [INS_W-1:0]  s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] ins_index,
  output logic              ins_we,
  output logic [INS_W-1:0]  instructs,
  output logic              cpu_run,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              err_overflow
);

  // One extra bit so the pointer can express DEPTH itself when DEPTH == 2^ADDR_W.
  localparam int              PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  load_state_t      state;
  load_state_t      state_next;
  logic [PTR_W-1:0] ptr;
  logic             beat;
  logic             ready_next;
  logic             busy_next;
  logic             run_next;

  assign beat = (state == ST_LOAD) && s_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load ends on s_last or on the beat that fills the last entry. Filling
  // the last entry without s_last is an overflow and aborts back to IDLE.
  // busy is held through the cycle that presents the final write so that it
  // falls together with the rise of cpu_run one cycle later.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (beat && (s_last || ptr == LAST_PTR)) begin
          if (ptr < LAST_PTR)  state_next = ST_FILL;
          else if (s_last)     state_next = ST_RUN;
          else                 state_next = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (ptr == LAST_PTR) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    ready_next = (state_next == ST_LOAD);
    busy_next  = (state_next == ST_LOAD) || (state_next == ST_FILL) ||
                 ((state_next == ST_RUN) && (state != ST_RUN));
    run_next   = (state == ST_RUN) && (state_next == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      s_ready      <= 1'b0;
      ins_index    <= '0;
      ins_we       <= 1'b0;
      instructs    <= '0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      s_ready <= ready_next;
      busy    <= busy_next;
      cpu_run <= run_next;
      ins_we  <= 1'b0;

      if ((state == ST_IDLE) && start) begin
        ptr          <= '0;
        count        <= '0;
        err_overflow <= 1'b0;
      end

      if (beat) begin
        ins_we    <= 1'b1;
        ins_index <= ptr[ADDR_W-1:0];
        instructs <= s_data;
        ptr       <= ptr + PTR_W'(1);
        count     <= count + PTR_W'(1);
        if (state_next == ST_IDLE) err_overflow <= 1'b1;
      end

      if (state == ST_FILL) begin
        ins_we    <= 1'b1;
        ins_index <= ptr[ADDR_W-1:0];
        instructs <= NOP;
        ptr       <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scpu_loader.sv
// tb_scpu_loader
//   Self-checking bench for scpu_loader. A cycle-level behavioural model
//   tracks words accepted, NOPs still owed and run status; a compare loop
//   checks every DUT output against it on each falling edge. Directed and
//   randomized loads cover full, short, gapped, overflowing and reset-
//   interrupted programs, plus the start/stop corner cases.
module tb_scpu_loader;

  localparam int        DEPTH = 128;
  localparam logic [15:0] NOP = 16'h0000;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_FILL   = 2;
  localparam int P_SETTLE = 3;
  localparam int P_RUN    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic [7:0]  ins_index;
  logic        ins_we;
  logic [15:0] instructs;
  logic        cpu_run;
  logic        busy;
  logic [8:0]  count;
  logic        err_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state and expected outputs for the current cycle
  int          m_phase    = P_IDLE;
  int          m_words    = 0;
  int          m_nop_left = 0;
  bit          e_ready    = 1'b0;
  bit          e_we       = 1'b0;
  int          e_idx      = 0;
  logic [15:0] e_data     = 16'h0000;
  bit          e_run      = 1'b0;
  bit          e_busy     = 1'b0;
  int          e_count    = 0;
  bit          e_err      = 1'b0;

  // image of what the DUT wrote, and writes seen since the last clear
  logic [15:0] img [0:255];
  int          wr_total = 0;

  scpu_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .ins_index    (ins_index),
    .ins_we       (ins_we),
    .instructs    (instructs),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .count        (count),
    .err_overflow (err_overflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: advances one clock using the rules of the loader.
  task automatic modelStep();
    if (rst) begin
      m_phase = P_IDLE; m_words = 0; m_nop_left = 0;
      e_ready = 0; e_we = 0; e_idx = 0; e_data = 16'h0000;
      e_run = 0; e_busy = 0; e_count = 0; e_err = 0;
      return;
    end
    e_we = 0;
    case (m_phase)
      P_IDLE: begin
        if (start) begin
          m_phase = P_LOAD; m_words = 0; e_count = 0; e_err = 0;
        end
      end
      P_LOAD: begin
        if (s_valid) begin
          e_we = 1; e_idx = m_words; e_data = s_data;
          m_words++;
          e_count = m_words;
          if (!s_last && m_words == DEPTH) begin
            e_err = 1; m_phase = P_IDLE;
          end else if (s_last || m_words == DEPTH) begin
            m_nop_left = DEPTH - m_words;
            m_phase = (m_nop_left > 0) ? P_FILL : P_SETTLE;
          end
        end
      end
      P_FILL: begin
        e_we = 1; e_idx = DEPTH - m_nop_left; e_data = NOP;
        m_nop_left--;
        if (m_nop_left == 0) m_phase = P_SETTLE;
      end
      P_SETTLE: m_phase = stop ? P_IDLE : P_RUN;
      P_RUN: begin
        if (stop) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    e_ready = (m_phase == P_LOAD);
    e_busy  = (m_phase == P_LOAD) || (m_phase == P_FILL) || (m_phase == P_SETTLE);
    e_run   = (m_phase == P_RUN);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    modelStep();
  end

  // Compare loop: every falling edge outside reset.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checkOutput("s_ready", 32'(s_ready), 32'(e_ready));
      checkOutput("ins_we", 32'(ins_we), 32'(e_we));
      checkOutput("cpu_run", 32'(cpu_run), 32'(e_run));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("count", 32'(count), 32'(e_count));
      checkOutput("err_overflow", 32'(err_overflow), 32'(e_err));
      if (e_we) begin
        checkOutput("ins_index", 32'(ins_index), 32'(e_idx));
        checkOutput("instructs", 32'(instructs), 32'(e_data));
      end
      if (ins_we) begin
        img[ins_index] = instructs;
        wr_total++;
      end
    end
  end

  // Drive one control pulse; called and returns on a falling edge.
  task automatic pulseCtl(input bit s, input bit p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Offer n words. mode 0: always valid, 1: valid toggles, 2: random valid.
  task automatic applyStimulus(input int n, input bit with_last, input int mode,
                               input logic [15:0] base, input bit rand_data,
                               input int limit, output int accepted);
    int  sent = 0;
    int  cyc  = 0;
    bit  v;
    bit  acc;
    while (sent < n && cyc < limit) begin
      case (mode)
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      s_valid = v;
      s_data  = rand_data ? 16'($urandom) : base + 16'(sent);
      s_last  = with_last && (sent == n - 1);
      acc     = v && s_ready;
      @(negedge clk);
      if (acc) sent++;
      cyc++;
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    accepted = sent;
  endtask

  task automatic waitRun(input int limit);
    int i = 0;
    while (!cpu_run && i < limit) begin
      @(negedge clk);
      i++;
    end
    checkOutput("run_reached", 32'(cpu_run), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    checkOutput({tag, "_ins_index"}, 32'(ins_index), 32'd0);
    checkOutput({tag, "_ins_we"}, 32'(ins_we), 32'd0);
    checkOutput({tag, "_instructs"}, 32'(instructs), 32'd0);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_overflow), 32'd0);
  endtask

  initial begin
    int acc;
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // full-length program, no fill
    $display("[TB] full-length load");
    wr_total = 0;
    pulseCtl(1'b1, 1'b0);
    applyStimulus(DEPTH, 1'b1, 0, 16'h0001, 1'b0, 400, acc);
    checkOutput("full_accepted", 32'(acc), 32'd128);
    waitRun(50);
    checkOutput("full_count", 32'(count), 32'd128);
    checkOutput("full_img0", 32'(img[0]), 32'h0001);
    checkOutput("full_img127", 32'(img[127]), 32'h0080);
    checkOutput("full_writes", 32'(wr_total), 32'd128);

    // start ignored while running, stop halts on the next cycle
    pulseCtl(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("run_ignores_start", 32'(cpu_run), 32'd1);
    pulseCtl(1'b0, 1'b1);
    checkOutput("stop_drops_run", 32'(cpu_run), 32'd0);
    @(negedge clk);

    // short program with NOP tail
    $display("[TB] short program");
    wr_total = 0;
    pulseCtl(1'b1, 1'b0);
    applyStimulus(3, 1'b1, 0, 16'hA001, 1'b0, 50, acc);
    waitRun(200);
    checkOutput("short_count", 32'(count), 32'd3);
    checkOutput("short_model_count", 32'(e_count), 32'd3);
    checkOutput("short_img2", 32'(img[2]), 32'hA003);
    checkOutput("short_img3", 32'(img[3]), 32'h0000);
    checkOutput("short_img127", 32'(img[127]), 32'h0000);
    checkOutput("short_writes", 32'(wr_total), 32'd128);
    pulseCtl(1'b0, 1'b1);

    // handshake gaps
    $display("[TB] toggled valid");
    wr_total = 0;
    pulseCtl(1'b1, 1'b0);
    applyStimulus(10, 1'b1, 1, 16'h5A00, 1'b0, 100, acc);
    waitRun(200);
    checkOutput("gap_count", 32'(count), 32'd10);
    checkOutput("gap_img9", 32'(img[9]), 32'h5A09);
    checkOutput("gap_img10", 32'(img[10]), 32'h0000);
    checkOutput("gap_writes", 32'(wr_total), 32'd128);
    pulseCtl(1'b0, 1'b1);

    // randomized programs
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, DEPTH);
      $display("[TB] random load %0d words", n);
      wr_total = 0;
      pulseCtl(1'b1, 1'b0);
      applyStimulus(n, 1'b1, 2, 16'h0000, 1'b1, 8 * n + 50, acc);
      checkOutput("rand_accepted", 32'(acc), 32'(n));
      waitRun(200);
      checkOutput("rand_count", 32'(count), 32'(n));
      checkOutput("rand_writes", 32'(wr_total), 32'd128);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulseCtl(1'b0, 1'b1);
    end

    // overflow: 129 words without s_last
    $display("[TB] overflow");
    wr_total = 0;
    pulseCtl(1'b1, 1'b0);
    applyStimulus(DEPTH + 1, 1'b0, 0, 16'h1000, 1'b0, 200, acc);
    checkOutput("ovf_accepted", 32'(acc), 32'd128);
    checkOutput("ovf_err", 32'(err_overflow), 32'd1);
    checkOutput("ovf_ready", 32'(s_ready), 32'd0);
    checkOutput("ovf_run", 32'(cpu_run), 32'd0);
    checkOutput("ovf_count", 32'(count), 32'd128);
    checkOutput("ovf_writes", 32'(wr_total), 32'd128);
    checkOutput("ovf_img0", 32'(img[0]), 32'h1000);
    checkOutput("ovf_img127", 32'(img[127]), 32'h107F);
    repeat (5) @(negedge clk);
    checkOutput("ovf_still_idle", 32'(cpu_run), 32'd0);

    // reset in the middle of a load, then restart with start+stop together
    $display("[TB] reset mid-load");
    pulseCtl(1'b1, 1'b0);
    applyStimulus(5, 1'b0, 0, 16'h2000, 1'b0, 50, acc);
    #2 rst = 1'b1;
    #1 checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulseCtl(1'b1, 1'b1);
    checkOutput("startstop_ready", 32'(s_ready), 32'd1);
    checkOutput("startstop_busy", 32'(busy), 32'd1);
    applyStimulus(4, 1'b1, 2, 16'h3000, 1'b0, 100, acc);
    waitRun(200);
    checkOutput("reload_count", 32'(count), 32'd4);
    checkOutput("reload_img0", 32'(img[0]), 32'h3000);
    checkOutput("reload_img3", 32'(img[3]), 32'h3003);
    pulseCtl(1'b0, 1'b1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
